// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline register between MiniMIPS32
// stages. Carries payload, exception code, PC, badvaddr and delay-slot flag.
//
// Build option: define PIPE_STAGE_SKID_EN to add a skid entry. With it,
// in_ready is a pure register output and occupancy ranges 0..2. Without it
// the stage is a single register whose in_ready is combinational from
// out_ready, and occupancy[1] is always 0.
//
// Whenever out_valid is low every out_* field holds its idle value
// (zero, exception code EC_NONE), so downstream never sees stale state.

module pipe_stage_buf #(
    parameter int unsigned      DATA_W  = 32,
    parameter int unsigned      EXC_W   = 5,
    parameter logic [EXC_W-1:0] EC_NONE = {EXC_W{1'b0}},
    parameter int unsigned      PC_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_badvaddr,
    input  logic              in_in_delay,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_badvaddr,
    output logic              out_in_delay,
    output logic [1:0]        occupancy
);

    // One held instruction slot: everything that travels with the instruction.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc_code;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   badvaddr;
        logic              in_delay;
    } entry_t;

    // Value an empty slot carries; used on reset, flush and bubble.
    function automatic entry_t idle_entry();
        entry_t e;
        e.data     = {DATA_W{1'b0}};
        e.exc_code = EC_NONE;
        e.pc       = {PC_W{1'b0}};
        e.badvaddr = {PC_W{1'b0}};
        e.in_delay = 1'b0;
        return e;
    endfunction

    // Main entry drives the outputs directly.
    entry_t     r_main;
    logic       r_main_valid;
    logic [1:0] r_occupancy;

    entry_t     w_in_entry;
    entry_t     w_main_nxt;
    logic       w_main_valid_nxt;
    logic [1:0] w_occ_nxt;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_consume;

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry: catches an input accepted while main is stalled.
    entry_t     r_skid;
    logic       r_skid_valid;
    entry_t     w_skid_nxt;
    logic       w_skid_valid_nxt;
`endif

    // Pack the upstream fields into one entry.
    always_comb begin
        w_in_entry          = idle_entry();
        w_in_entry.data     = in_data;
        w_in_entry.exc_code = in_exc_code;
        w_in_entry.pc       = in_pc;
        w_in_entry.badvaddr = in_badvaddr;
        w_in_entry.in_delay = in_in_delay;
    end

`ifdef PIPE_STAGE_SKID_EN
    // Ready only depends on the skid register, so out_ready never reaches in_ready.
    always_comb begin
        w_in_ready = ~r_skid_valid;
    end
`else
    // Single register: free when empty or when being drained this cycle.
    always_comb begin
        w_in_ready = ~r_main_valid | out_ready;
    end
`endif

    // Transfer strobes; flush overrides these at the register update.
    always_comb begin
        w_accept  = in_valid & w_in_ready;
        w_consume = r_main_valid & out_ready;
    end

`ifdef PIPE_STAGE_SKID_EN
    // Next-state for main and skid entries during normal operation.
    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
            // Full: no accept possible; a consume promotes the skid entry.
            if (w_consume) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_nxt       = idle_entry();
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_main_nxt       = r_main;
                w_skid_nxt       = r_skid;
            end
        end else if (r_main_valid) begin
            if (w_accept && w_consume) begin
                // Steady flow: replace main in place.
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = 1'b1;
            end else if (w_accept) begin
                // Main stalled: park the new entry in the skid slot.
                w_skid_nxt       = w_in_entry;
                w_skid_valid_nxt = 1'b1;
            end else if (w_consume) begin
                // Drained with nothing behind it: insert a bubble.
                w_main_nxt       = idle_entry();
                w_main_valid_nxt = 1'b0;
            end else begin
                w_main_nxt       = r_main;
            end
        end else begin
            // Empty: out_ready is irrelevant, only an accept matters.
            if (w_accept) begin
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_main_nxt       = r_main;
            end
        end
    end

    // Occupancy counts both slots.
    always_comb begin
        w_occ_nxt = {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
    end
`else
    // Next-state for the single main entry during normal operation.
    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        if (w_accept) begin
            // Covers both fill-from-empty and consume-and-replace.
            w_main_nxt       = w_in_entry;
            w_main_valid_nxt = 1'b1;
        end else if (w_consume) begin
            // Drained with no new input: insert a bubble.
            w_main_nxt       = idle_entry();
            w_main_valid_nxt = 1'b0;
        end else begin
            w_main_nxt       = r_main;
        end
    end

    // Occupancy is 0 or 1 with a single register.
    always_comb begin
        w_occ_nxt = {1'b0, w_main_valid_nxt};
    end
`endif

    // Main entry state: reset beats flush beats normal update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= idle_entry();
            r_main_valid <= 1'b0;
            r_occupancy  <= 2'd0;
        end else if (flush) begin
            r_main       <= idle_entry();
            r_main_valid <= 1'b0;
            r_occupancy  <= 2'd0;
        end else begin
            r_main       <= w_main_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_occupancy  <= w_occ_nxt;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry state: same priority as the main entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid       <= idle_entry();
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_skid       <= idle_entry();
            r_skid_valid <= 1'b0;
        end else begin
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end
`endif

    assign in_ready     = w_in_ready;
    assign out_valid    = r_main_valid;
    assign out_data     = r_main.data;
    assign out_exc_code = r_main.exc_code;
    assign out_pc       = r_main.pc;
    assign out_badvaddr = r_main.badvaddr;
    assign out_in_delay = r_main.in_delay;
    assign occupancy    = r_occupancy;

endmodule
